// File: rtl/stopwatch_counter.sv
// Purpose : MM:SS.hh stopwatch core; BCD up/down count advanced by a CLK_DIV prescaler tick,
//           with clear, saturating preset load and an optional frozen lap display.
// Latency : every control takes effect on the next clk edge; done is registered and is high
//           in the first cycle the live count shows 00:00.00 after a down-count from 00:00.01.
// Backpressure: none; every request is accepted on the cycle it is seen.
//
// Ports
//   clk, rst                   : clock, asynchronous active-high reset
//   running, dir               : count enable level, direction (1 = up, 0 = down)
//   clear_pulse, preset_load   : synchronous clear / preset request (clear wins)
//   preset_{min,sec}_{t,o}     : BCD preset digits, saturated on load
//   lap_btn                    : lap toggle request (used only with STOPWATCH_LAP_EN)
//   {min,sec,hs}_{t,o}         : displayed BCD digits
//   done, at_zero, lap_active  : down-count completion pulse, live-zero level, lap freeze level
//
// Build option: define STOPWATCH_LAP_EN to include the lap register and lap display freeze.
module stopwatch_counter #(
    parameter int CLK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       running,
    input  logic       dir,
    input  logic       clear_pulse,
    input  logic       preset_load,
    input  logic [3:0] preset_min_t,
    input  logic [3:0] preset_min_o,
    input  logic [3:0] preset_sec_t,
    input  logic [3:0] preset_sec_o,
    input  logic       lap_btn,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [3:0] hs_t,
    output logic [3:0] hs_o,
    output logic       done,
    output logic       at_zero,
    output logic       lap_active
);

    localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] hs_t;
        logic [3:0] hs_o;
    } bcd_time_t;

    // Advance one digit when all lower digits roll over; top is the digit's maximum value.
    function automatic logic [3:0] step_up(input logic [3:0] d, input logic [3:0] top,
                                           input logic cin);
        logic [3:0] r;
        r = d;
        if (cin) r = (d == top) ? 4'd0 : d + 4'd1;
        return r;
    endfunction

    function automatic logic [3:0] step_dn(input logic [3:0] d, input logic [3:0] top,
                                           input logic bin);
        logic [3:0] r;
        r = d;
        if (bin) r = (d == 4'd0) ? top : d - 4'd1;
        return r;
    endfunction

    function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] top);
        return (d > top) ? top : d;
    endfunction

    bcd_time_t     live_q, live_d;
    bcd_time_t     up_val, dn_val;
    bcd_time_t     disp;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
    logic          tick;
    logic          live_zero, live_one;
    logic          cu1, cu2, cu3, cu4, cu5;
    logic          bd1, bd2, bd3, bd4, bd5;

    assign tick      = running && (pre_q == PRE_MAX);
    assign live_zero = (live_q == 24'h000000);
    assign live_one  = (live_q == 24'h000001);

    // Ripple carry/borrow conditions: a digit moves when every lower digit wraps.
    assign cu1 = (live_q.hs_o  == 4'd9);
    assign cu2 = cu1 && (live_q.hs_t  == 4'd9);
    assign cu3 = cu2 && (live_q.sec_o == 4'd9);
    assign cu4 = cu3 && (live_q.sec_t == 4'd5);
    assign cu5 = cu4 && (live_q.min_o == 4'd9);

    assign bd1 = (live_q.hs_o  == 4'd0);
    assign bd2 = bd1 && (live_q.hs_t  == 4'd0);
    assign bd3 = bd2 && (live_q.sec_o == 4'd0);
    assign bd4 = bd3 && (live_q.sec_t == 4'd0);
    assign bd5 = bd4 && (live_q.min_o == 4'd0);

    always_comb begin
        up_val.hs_o  = step_up(live_q.hs_o,  4'd9, 1'b1);
        up_val.hs_t  = step_up(live_q.hs_t,  4'd9, cu1);
        up_val.sec_o = step_up(live_q.sec_o, 4'd9, cu2);
        up_val.sec_t = step_up(live_q.sec_t, 4'd5, cu3);
        up_val.min_o = step_up(live_q.min_o, 4'd9, cu4);
        up_val.min_t = step_up(live_q.min_t, 4'd5, cu5);
    end

    always_comb begin
        dn_val.hs_o  = step_dn(live_q.hs_o,  4'd9, 1'b1);
        dn_val.hs_t  = step_dn(live_q.hs_t,  4'd9, bd1);
        dn_val.sec_o = step_dn(live_q.sec_o, 4'd9, bd2);
        dn_val.sec_t = step_dn(live_q.sec_t, 4'd5, bd3);
        dn_val.min_o = step_dn(live_q.min_o, 4'd9, bd4);
        dn_val.min_t = step_dn(live_q.min_t, 4'd5, bd5);
    end

    // Clear beats preset beats tick; a discarded tick still restarts the prescaler at 0.
    always_comb begin
        live_d = live_q;
        pre_d  = pre_q;
        done_d = 1'b0;
        if (clear_pulse) begin
            live_d = '0;
            pre_d  = '0;
        end else if (preset_load) begin
            live_d.min_t = sat(preset_min_t, 4'd5);
            live_d.min_o = sat(preset_min_o, 4'd9);
            live_d.sec_t = sat(preset_sec_t, 4'd5);
            live_d.sec_o = sat(preset_sec_o, 4'd9);
            live_d.hs_t  = 4'd0;
            live_d.hs_o  = 4'd0;
            pre_d        = '0;
        end else if (running) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                if (dir) begin
                    live_d = up_val;
                end else if (!live_zero) begin
                    live_d = dn_val;
                    done_d = live_one;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            pre_q  <= '0;
            done_q <= 1'b0;
        end else begin
            live_q <= live_d;
            pre_q  <= pre_d;
            done_q <= done_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic      lap_active_q, lap_active_d;
    bcd_time_t lap_q, lap_d;

    // Lap snapshot is the live value before this cycle's tick is applied.
    always_comb begin
        lap_active_d = lap_active_q;
        lap_d        = lap_q;
        if (clear_pulse || preset_load) begin
            lap_active_d = 1'b0;
        end else if (lap_btn && running) begin
            lap_active_d = !lap_active_q;
            if (!lap_active_q) lap_d = live_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_active_q <= 1'b0;
            lap_q        <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            lap_q        <= lap_d;
        end
    end

    assign disp       = lap_active_q ? lap_q : live_q;
    assign lap_active = lap_active_q;
`else
    logic unused_lap_btn;
    assign unused_lap_btn = lap_btn;
    assign disp           = live_q;
    assign lap_active     = 1'b0;
`endif

    assign min_t   = disp.min_t;
    assign min_o   = disp.min_o;
    assign sec_t   = disp.sec_t;
    assign sec_o   = disp.sec_o;
    assign hs_t    = disp.hs_t;
    assign hs_o    = disp.hs_o;
    assign done    = done_q;
    assign at_zero = live_zero;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Stopwatch bench: directed sequences with literal expectations, plus a per-cycle comparison
// against a model that keeps the live time as an integer count of hundredths of a second.
module tb_stopwatch_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       running = 1'b0;
    logic       dir = 1'b1;
    logic       clear_pulse = 1'b0;
    logic       preset_load = 1'b0;
    logic       lap_btn = 1'b0;
    logic [3:0] p_mt = 4'd0, p_mo = 4'd0, p_st = 4'd0, p_so = 4'd0;
    logic [3:0] min_t, min_o, sec_t, sec_o, hs_t, hs_o;
    logic       done, at_zero, lap_active;
    wire [23:0] disp = {min_t, min_o, sec_t, sec_o, hs_t, hs_o};

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    stopwatch_counter #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .running(running), .dir(dir),
        .clear_pulse(clear_pulse), .preset_load(preset_load),
        .preset_min_t(p_mt), .preset_min_o(p_mo), .preset_sec_t(p_st), .preset_sec_o(p_so),
        .lap_btn(lap_btn),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o), .hs_t(hs_t), .hs_o(hs_o),
        .done(done), .at_zero(at_zero), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int d, input int top);
        return (d > top) ? top : d;
    endfunction

    // Hundredths of a second -> displayed MM:SS.hh as six BCD nibbles.
    function automatic logic [23:0] to_bcd(input int cs);
        int mm, ss, hh;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        hh = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    // Model: time as an integer, prescaler as an integer phase.
    int m_cs = 0, m_pre = 0, m_lap_cs = 0;
    bit m_done = 1'b0, m_lap = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cs     <= 0;
            m_pre    <= 0;
            m_done   <= 1'b0;
            m_lap    <= 1'b0;
            m_lap_cs <= 0;
        end else begin
            m_done <= 1'b0;
            if (clear_pulse) begin
                m_cs  <= 0;
                m_pre <= 0;
            end else if (preset_load) begin
                m_cs  <= (sat(p_mt, 5) * 10 + sat(p_mo, 9)) * 6000
                       + (sat(p_st, 5) * 10 + sat(p_so, 9)) * 100;
                m_pre <= 0;
            end else if (running) begin
                m_pre <= (m_pre + 1) % DIV;
                if (m_pre == DIV - 1) begin
                    if (dir) begin
                        m_cs <= (m_cs + 1) % 360000;
                    end else if (m_cs > 0) begin
                        m_cs   <= m_cs - 1;
                        m_done <= (m_cs == 1);
                    end
                end
            end
`ifdef STOPWATCH_LAP_EN
            if (clear_pulse || preset_load) begin
                m_lap <= 1'b0;
            end else if (lap_btn && running) begin
                m_lap <= !m_lap;
                if (!m_lap) m_lap_cs <= m_cs;
            end
`endif
        end
    end

    // Every cycle outside reset the outputs must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("disp", 32'(disp), 32'(to_bcd(m_lap ? m_lap_cs : m_cs)));
            check("done", 32'(done), 32'(m_done));
            check("at_zero", 32'(at_zero), 32'(m_cs == 0));
            check("lap_active", 32'(lap_active), 32'(m_lap));
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [3:0] mt, input logic [3:0] mo,
                        input logic [3:0] st, input logic [3:0] so);
        p_mt = mt; p_mo = mo; p_st = st; p_so = so;
        preset_load = 1'b1;
        cyc(1);
        preset_load = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(1);
        check("rst_disp", 32'(disp), 32'h0);
        check("rst_at_zero", 32'(at_zero), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_lap", 32'(lap_active), 32'h0);
        rst = 1'b0;

        // 400 clocks up = 100 ticks = one second
        running = 1'b1; dir = 1'b1;
        cyc(400);
        running = 1'b0;
        cyc(1);
        check("up_1s", 32'(disp), 32'h000100);
        check("up_1s_done", done_seen, 0);

        // Wrap from 59:59.00 by one second
        done_seen = 0;
        load(4'd5, 4'd9, 4'd5, 4'd9);
        check("preset_5959", 32'(disp), 32'h595900);
        running = 1'b1; dir = 1'b1;
        cyc(400);
        running = 1'b0;
        cyc(1);
        check("wrap_disp", 32'(disp), 32'h000000);
        check("wrap_no_done", done_seen, 0);

        // Down-count from 00:01.00 to zero, then hold at zero
        done_seen = 0;
        load(4'd0, 4'd0, 4'd0, 4'd1);
        check("preset_0001", 32'(disp), 32'h000100);
        check("nonzero_at_zero", 32'(at_zero), 32'h0);
        running = 1'b1; dir = 1'b0;
        cyc(400);
        running = 1'b0;
        cyc(1);
        check("down_disp", 32'(disp), 32'h000000);
        check("down_at_zero", 32'(at_zero), 32'h1);
        check("down_done_once", done_seen, 1);
        running = 1'b1;
        cyc(40);
        running = 1'b0;
        cyc(1);
        check("hold_disp", 32'(disp), 32'h000000);
        check("hold_no_redone", done_seen, 1);

        // Clear and preset together with a tick: clear wins
        done_seen = 0;
        load(4'd0, 4'd0, 4'd0, 4'd5);
        running = 1'b1; dir = 1'b1;
        cyc(3);
        p_mt = 4'd1; p_mo = 4'd2; p_st = 4'd3; p_so = 4'd4;
        clear_pulse = 1'b1; preset_load = 1'b1;
        cyc(1);
        clear_pulse = 1'b0; preset_load = 1'b0;
        check("clr_prio", 32'(disp), 32'h000000);
        // Preset together with a tick: preset wins, tick discarded
        cyc(3);
        preset_load = 1'b1;
        cyc(1);
        preset_load = 1'b0; running = 1'b0;
        check("preset_prio", 32'(disp), 32'h123400);
        check("prio_no_done", done_seen, 0);

        // Saturation of out-of-range preset digits
        load(4'd9, 4'd9, 4'd9, 4'd9);
        check("sat_9999", 32'(disp), 32'h595900);
        load(4'd7, 4'd3, 4'd8, 4'd2);
        check("sat_7382", 32'(disp), 32'h535200);

        // Lap: freeze at 00:02.50, release after 100 more ticks at 00:03.50
        clear_pulse = 1'b1;
        cyc(1);
        clear_pulse = 1'b0;
        running = 1'b1; dir = 1'b1;
        cyc(1000);
        check("pre_lap", 32'(disp), 32'h000250);
        lap_btn = 1'b1;
        cyc(1);
        lap_btn = 1'b0;
`ifdef STOPWATCH_LAP_EN
        check("lap_on", 32'(lap_active), 32'h1);
        cyc(399);
        check("lap_frozen", 32'(disp), 32'h000250);
`else
        check("lap_off", 32'(lap_active), 32'h0);
        cyc(399);
        check("lap_live", 32'(disp), 32'h000350);
`endif
        lap_btn = 1'b1;
        cyc(1);
        lap_btn = 1'b0;
        check("lap_release", 32'(lap_active), 32'h0);
        check("lap_release_disp", 32'(disp), 32'h000350);
        // lap_btn while stopped is ignored
        running = 1'b0;
        lap_btn = 1'b1;
        cyc(1);
        lap_btn = 1'b0;
        check("lap_stopped", 32'(lap_active), 32'h0);

        // Asynchronous reset mid-count, observed before any clock edge
        running = 1'b1;
        cyc(37);
        #2 rst = 1'b1;
        #1;
        check("arst_disp", 32'(disp), 32'h0);
        check("arst_at_zero", 32'(at_zero), 32'h1);
        check("arst_done", 32'(done), 32'h0);
        check("arst_lap", 32'(lap_active), 32'h0);
        cyc(2);
        rst = 1'b0;
        running = 1'b0;
        cyc(2);
        check("post_arst", 32'(disp), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000000, giving clk cycles per hundredth-second tick (100 MHz -> 100 Hz).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port running, input, 1, level from the control stage; 1 = count.
REQ-005 SHALL have port dir, input, 1, direction: 1 = up, 0 = down.
REQ-006 SHALL have port clear_pulse, input, 1, synchronous clear request.
REQ-007 SHALL have port preset_load, input, 1, single-cycle request to load the preset time.
REQ-008 SHALL have ports preset_min_t, preset_min_o, preset_sec_t, preset_sec_o, input, 4 each, BCD preset digits.
REQ-009 SHALL have port lap_btn, input, 1, single-cycle lap toggle request.
REQ-010 SHALL have ports min_t, min_o, sec_t, sec_o, hs_t, hs_o, output, 4 each, displayed BCD time MM:SS.hh.
REQ-011 SHALL have port done, output, 1, single-cycle pulse when a down-count reaches 00:00.00.
REQ-012 SHALL have port at_zero, output, 1, level; live count equals 00:00.00.
REQ-013 SHALL have port lap_active, output, 1, level; display is frozen.

Function
REQ-014 SHALL keep a prescaler 0..CLK_DIV-1 that advances only while running=1 and holds its value while running=0.
REQ-015 SHALL generate an internal tick on the cycle the prescaler is CLK_DIV-1 with running=1, wrapping the prescaler to 0.
REQ-016 SHALL, on a tick with dir=1, increment the live count by 0.01 s with BCD carry: hs 99->00, sec 59->00, min 59->00.
REQ-017 SHALL wrap 59:59.99 + tick to 00:00.00 with no done pulse.
REQ-018 SHALL, on a tick with dir=0 and count nonzero, decrement by 0.01 s with BCD borrow: hs 00->99, sec 00->59.
REQ-019 SHALL pulse done for exactly one cycle on the tick that moves a down-count from 00:00.01 to 00:00.00.
REQ-020 SHALL hold 00:00.00 on down ticks at zero; done SHALL not re-pulse.
REQ-021 SHALL, on clear_pulse, set the live count to 00:00.00 and the prescaler to 0 next cycle, with no done pulse.
REQ-022 SHALL, on preset_load, set the live count to preset MM:SS.00 and the prescaler to 0 next cycle.
REQ-023 SHALL saturate each out-of-range preset digit on load: tens digits >5 to 5, ones digits >9 to 9.
REQ-024 SHALL resolve simultaneous events by priority clear_pulse > preset_load > tick; the lower-priority events in that cycle are discarded.
REQ-025 SHALL accept clear_pulse and preset_load regardless of running.
REQ-026 SHALL drive at_zero combinationally from the live count.
REQ-027 SHALL drive the displayed digits from the live count when lap_active=0.

Reset
REQ-028 SHALL, while rst=1, force live count 00:00.00, prescaler 0, done=0, lap_active=0, lap register 00:00.00.
REQ-029 SHALL, in that reset state, present all digit outputs as 0 and at_zero=1.
REQ-030 SHALL, on rst mid-count, abandon the count immediately without waiting for clk.

Configuration
REQ-031 SHALL, with macro STOPWATCH_LAP_EN defined, toggle lap_active on lap_btn while running=1, capturing the live count into the lap register on the 0->1 transition.
REQ-032 SHALL, with STOPWATCH_LAP_EN defined, show the lap register on the displayed digits while lap_active=1, with live counting continuing underneath.
REQ-033 SHALL, with STOPWATCH_LAP_EN defined, ignore lap_btn while running=0, and force lap_active to 0 on clear_pulse or preset_load.
REQ-034 SHALL, without STOPWATCH_LAP_EN, ignore lap_btn, tie lap_active to 0, include no lap register, and always show the live count.

Verification (CLK_DIV=4)
REQ-035 SHALL cover: rst, then running=1, dir=1 for 400 clk -> display 00:01.00, done never 1.
REQ-036 SHALL cover: preset 59:59 load, then 100 up ticks -> 00:00.00, no done.
REQ-037 SHALL cover: preset 00:01 load, dir=0 for 100 ticks -> 00:00.00, done high exactly one cycle; 10 further ticks -> still 00:00.00, no done.
REQ-038 SHALL cover: clear_pulse and preset_load (preset 12:34) in the same cycle as a tick -> 00:00.00.
REQ-039 SHALL cover: preset digits 9,9,9,9 loaded -> 59:59.00.
REQ-040 SHALL cover: with STOPWATCH_LAP_EN, lap_btn at 00:02.50 -> display frozen at 00:02.50; second lap_btn after 100 ticks -> 00:03.50.
